// File: rtl/hazard_scoreboard_if.sv
// D-stage hazard descriptor bus: decoder-side instruction timing/register info in,
// stall, forward selects and mult/div busy back out.
interface hazard_scoreboard_if;
  logic [1:0] d_tuse1;
  logic [1:0] d_tuse2;
  logic [4:0] d_reada1;
  logic [4:0] d_reada2;
  logic [1:0] d_tnew;
  logic [4:0] d_writea;
  logic [1:0] d_md_op;
  logic       d_md_use;
  logic       stall;
  logic [1:0] fwd_rs_sel;
  logic [1:0] fwd_rt_sel;
  logic       md_busy;

  modport master (
    output d_tuse1, d_tuse2, d_reada1, d_reada2, d_tnew, d_writea, d_md_op, d_md_use,
    input  stall, fwd_rs_sel, fwd_rt_sel, md_busy
  );

  modport slave (
    input  d_tuse1, d_tuse2, d_reada1, d_reada2, d_tnew, d_writea, d_md_op, d_md_use,
    output stall, fwd_rs_sel, fwd_rt_sel, md_busy
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Tuse/Tnew hazard scheduler for a 5-stage MIPS pipeline: tracks E/M/W destinations,
// raises the D-stage stall, picks D-stage forward sources and times the mult/div unit.
module hazard_scoreboard #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input logic                clk,
  input logic                reset,
  hazard_scoreboard_if.slave hs
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

  // In-flight entries; index 0 = rs operand, 1 = rt operand for per-operand arrays.
  logic [4:0]       e_writea_reg, m_writea_reg, w_writea_reg;
  logic [1:0]       e_tnew_reg, m_tnew_reg, w_tnew_reg;
  logic [1:0]       e_md_op_reg;
  logic [CNT_W-1:0] busy_cnt_reg;

  logic [4:0]       e_writea_next, m_writea_next, w_writea_next;
  logic [1:0]       e_tnew_next, m_tnew_next, w_tnew_next;
  logic [1:0]       e_md_op_next;
  logic [CNT_W-1:0] busy_cnt_next;

  logic [4:0] rd_addr [2];
  logic [1:0] rd_tuse [2];
  logic [1:0] fwd_sel [2];
  logic [1:0] e_hit, m_hit, w_hit, hazard;
  logic       md_stall;
  logic       stall;
  logic       md_busy;
  logic [1:0] d_md_op_eff;

  function automatic logic [1:0] dec2(input logic [1:0] x);
    return (x == 2'd0) ? 2'd0 : x - 2'd1;
  endfunction

  assign rd_addr[0] = hs.d_reada1;
  assign rd_addr[1] = hs.d_reada2;
  assign rd_tuse[0] = hs.d_tuse1;
  assign rd_tuse[1] = hs.d_tuse2;

  // Register 0 is hardwired, so an operand address of 0 can never hit any stage.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_operand
      assign e_hit[gi] = (rd_addr[gi] != 5'd0) && (e_writea_reg == rd_addr[gi]);
      assign m_hit[gi] = (rd_addr[gi] != 5'd0) && (m_writea_reg == rd_addr[gi]);
      assign w_hit[gi] = (rd_addr[gi] != 5'd0) && (w_writea_reg == rd_addr[gi]);

      assign hazard[gi] = (e_hit[gi] && (e_tnew_reg > rd_tuse[gi])) ||
                          (m_hit[gi] && (m_tnew_reg > rd_tuse[gi]));

      // Nearest producer wins; if it is not ready yet the stall logic owns the case.
      assign fwd_sel[gi] = e_hit[gi] ? ((e_tnew_reg == 2'd0) ? 2'd1 : 2'd0) :
                           m_hit[gi] ? ((m_tnew_reg == 2'd0) ? 2'd2 : 2'd0) :
                           w_hit[gi] ? ((w_tnew_reg == 2'd0) ? 2'd3 : 2'd0) :
                                       2'd0;
    end
  endgenerate

  assign md_busy     = (busy_cnt_reg != '0);
  assign md_stall    = hs.d_md_use && (md_busy || (e_md_op_reg != 2'd0));
  assign stall       = (|hazard) || md_stall;
  assign d_md_op_eff = (hs.d_md_op == 2'd3) ? 2'd0 : hs.d_md_op;

  assign hs.stall      = stall;
  assign hs.fwd_rs_sel = fwd_sel[0];
  assign hs.fwd_rt_sel = fwd_sel[1];
  assign hs.md_busy    = md_busy;

  always_comb begin
    w_writea_next = m_writea_reg;
    w_tnew_next   = dec2(m_tnew_reg);
    m_writea_next = e_writea_reg;
    m_tnew_next   = dec2(e_tnew_reg);
    e_writea_next = 5'd0;
    e_tnew_next   = 2'd0;
    e_md_op_next  = 2'd0;
    if (!stall) begin
      e_writea_next = hs.d_writea;
      e_tnew_next   = dec2(hs.d_tnew);
      e_md_op_next  = d_md_op_eff;
    end
  end

  // A mult/div leaving E reloads the counter even if an earlier one is still counting.
  always_comb begin
    busy_cnt_next = busy_cnt_reg;
    case (e_md_op_reg)
      2'd1:    busy_cnt_next = MULT_LOAD;
      2'd2:    busy_cnt_next = DIV_LOAD;
      default: if (md_busy) busy_cnt_next = busy_cnt_reg - 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_writea_reg <= 5'd0;
      e_tnew_reg   <= 2'd0;
      m_writea_reg <= 5'd0;
      m_tnew_reg   <= 2'd0;
      w_writea_reg <= 5'd0;
      w_tnew_reg   <= 2'd0;
      e_md_op_reg  <= 2'd0;
      busy_cnt_reg <= '0;
    end else begin
      e_writea_reg <= e_writea_next;
      e_tnew_reg   <= e_tnew_next;
      m_writea_reg <= m_writea_next;
      m_tnew_reg   <= m_tnew_next;
      w_writea_reg <= w_writea_next;
      w_tnew_reg   <= w_tnew_next;
      e_md_op_reg  <= e_md_op_next;
      busy_cnt_reg <= busy_cnt_next;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed scoreboard bench: each issued D-stage vector queues its hand-derived
// expectation; a negedge monitor pops and compares against the DUT outputs.
module tb_hazard_scoreboard;

  typedef struct {
    string      name;
    logic       stall;
    logic [1:0] rs;
    logic [1:0] rt;
    logic       busy;
  } exp_t;

  logic clk;
  logic reset;
  exp_t exp_q [$];
  int   n_vec;
  int   n_bad;

  hazard_scoreboard_if hs_if ();

  hazard_scoreboard #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10),
    .CNT_W      (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .hs   (hs_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, vectors=%0d required=29", n_vec);
    $fatal(1, "watchdog expired");
  end

  // Drives one D-stage instruction for a cycle and queues what the outputs must be.
  task automatic issue(input string name, input logic rst_v,
                       input logic [1:0] tu1, input logic [1:0] tu2,
                       input logic [4:0] ra1, input logic [4:0] ra2,
                       input logic [1:0] tn, input logic [4:0] wa,
                       input logic [1:0] mdop, input logic mduse,
                       input logic es, input logic [1:0] ers,
                       input logic [1:0] ert, input logic eb);
    exp_t e;
    @(posedge clk);
    #1;
    reset             = rst_v;
    hs_if.d_tuse1     = tu1;
    hs_if.d_tuse2     = tu2;
    hs_if.d_reada1    = ra1;
    hs_if.d_reada2    = ra2;
    hs_if.d_tnew      = tn;
    hs_if.d_writea    = wa;
    hs_if.d_md_op     = mdop;
    hs_if.d_md_use    = mduse;
    e.name  = name;
    e.stall = es;
    e.rs    = ers;
    e.rt    = ert;
    e.busy  = eb;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_vec++;
      $display("vec %-14s stall=%0b rs=%0d rt=%0d busy=%0b", e.name,
               hs_if.stall, hs_if.fwd_rs_sel, hs_if.fwd_rt_sel, hs_if.md_busy);
      if (hs_if.stall !== e.stall || hs_if.fwd_rs_sel !== e.rs ||
          hs_if.fwd_rt_sel !== e.rt || hs_if.md_busy !== e.busy) begin
        n_bad++;
        $display("FAIL %s: got stall=%0b rs=%0d rt=%0d busy=%0b, expected stall=%0b rs=%0d rt=%0d busy=%0b",
                 e.name, hs_if.stall, hs_if.fwd_rs_sel, hs_if.fwd_rt_sel, hs_if.md_busy,
                 e.stall, e.rs, e.rt, e.busy);
      end
    end
  end

  initial begin
    n_vec = 0;
    n_bad = 0;
    reset = 1'b1;
    hs_if.d_tuse1  = 2'd0;
    hs_if.d_tuse2  = 2'd0;
    hs_if.d_reada1 = 5'd0;
    hs_if.d_reada2 = 5'd0;
    hs_if.d_tnew   = 2'd0;
    hs_if.d_writea = 5'd0;
    hs_if.d_md_op  = 2'd0;
    hs_if.d_md_use = 1'b0;

    //     name            rst tu1 tu2 ra1 ra2 tn  wa  md  use  stall rs rt busy
    issue("reset",         1, 1, 1, 5'd1, 5'd1, 3, 5'd0, 0, 1,   0, 0, 0, 0);
    // load-use: lw $1 then addu $2,$1,$1, then a second reader of $1
    issue("lw_1",          0, 0, 0, 5'd0, 5'd0, 3, 5'd1, 0, 0,   0, 0, 0, 0);
    issue("addu_stall",    0, 1, 1, 5'd1, 5'd1, 1, 5'd2, 0, 0,   1, 0, 0, 0);
    issue("addu_go_m",     0, 1, 1, 5'd1, 5'd1, 1, 5'd2, 0, 0,   0, 0, 0, 0);
    issue("addu5_fwd_w",   0, 1, 1, 5'd1, 5'd1, 1, 5'd5, 0, 0,   0, 3, 3, 0);
    // ori $1 then beq $1,$0
    issue("ori_1",         0, 0, 0, 5'd0, 5'd0, 2, 5'd1, 0, 0,   0, 0, 0, 0);
    issue("beq_stall",     0, 0, 0, 5'd1, 5'd0, 0, 5'd0, 0, 0,   1, 0, 0, 0);
    issue("beq_fwd_m",     0, 0, 0, 5'd1, 5'd0, 0, 5'd0, 0, 0,   0, 2, 0, 0);
    // lui $3 then sw reading $3 as rt
    issue("lui_3",         0, 0, 0, 5'd0, 5'd0, 1, 5'd3, 0, 0,   0, 0, 0, 0);
    issue("sw_fwd_e",      0, 1, 2, 5'd0, 5'd3, 0, 5'd0, 0, 0,   0, 0, 1, 0);
    // two writers of $4 land in M and W; M must win
    issue("addu4_a",       0, 0, 0, 5'd0, 5'd0, 1, 5'd4, 0, 0,   0, 0, 0, 0);
    issue("addu4_b",       0, 0, 0, 5'd0, 5'd0, 1, 5'd4, 0, 0,   0, 0, 0, 0);
    issue("nop",           0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0,   0, 0, 0, 0);
    issue("rd4_m_over_w",  0, 1, 1, 5'd4, 5'd4, 0, 5'd0, 0, 0,   0, 2, 2, 0);
    // mult then mflo: six stall cycles, five busy cycles
    issue("mult",          0, 1, 1, 5'd0, 5'd0, 0, 5'd0, 1, 1,   0, 0, 0, 0);
    issue("mflo_e_mdop",   0, 0, 0, 5'd0, 5'd0, 1, 5'd7, 0, 1,   1, 0, 0, 0);
    issue("mflo_busy5",    0, 0, 0, 5'd0, 5'd0, 1, 5'd7, 0, 1,   1, 0, 0, 1);
    issue("mflo_busy4",    0, 0, 0, 5'd0, 5'd0, 1, 5'd7, 0, 1,   1, 0, 0, 1);
    issue("mflo_busy3",    0, 0, 0, 5'd0, 5'd0, 1, 5'd7, 0, 1,   1, 0, 0, 1);
    issue("mflo_busy2",    0, 0, 0, 5'd0, 5'd0, 1, 5'd7, 0, 1,   1, 0, 0, 1);
    issue("mflo_busy1",    0, 0, 0, 5'd0, 5'd0, 1, 5'd7, 0, 1,   1, 0, 0, 1);
    issue("mflo_go",       0, 0, 0, 5'd0, 5'd0, 1, 5'd7, 0, 1,   0, 0, 0, 0);
    // div, then reset asynchronously during the third busy cycle
    issue("div",           0, 1, 1, 5'd0, 5'd0, 0, 5'd0, 2, 1,   0, 0, 0, 0);
    issue("addu_8",        0, 0, 0, 5'd0, 5'd0, 1, 5'd8, 0, 0,   0, 0, 0, 0);
    issue("mfhi_busy1",    0, 1, 1, 5'd8, 5'd0, 1, 5'd9, 0, 1,   1, 1, 0, 1);
    issue("mfhi_busy2",    0, 1, 1, 5'd8, 5'd0, 1, 5'd9, 0, 1,   1, 2, 0, 1);
    issue("mfhi_rst_busy3",1, 1, 1, 5'd8, 5'd0, 1, 5'd9, 0, 1,   0, 0, 0, 0);
    issue("mfhi_post_rst", 0, 1, 1, 5'd8, 5'd0, 1, 5'd9, 0, 1,   0, 0, 0, 0);
    issue("rd9_fwd_e",     0, 1, 1, 5'd9, 5'd0, 0, 5'd0, 0, 0,   0, 1, 0, 0);

    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    if (n_vec != 29) begin
      n_bad++;
      $display("FAIL count: %0d vectors checked, required 29", n_vec);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
